// File: rtl/control.sv
// Multicycle control FSM for the LC-3b core: sequences fetch/decode/execute and
// decodes the current state into datapath load enables, mux selects and memory requests.
module control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluAnd  = 3'b001;
  localparam logic [2:0] AluNot  = 3'b010;
  localparam logic [2:0] AluPass = 3'b011;

  typedef enum logic [3:0] {
    StFetch1,
    StFetch2,
    StFetch3,
    StDecode,
    StAdd,
    StAnd,
    StNot,
    StBr,
    StBrTaken,
    StCalcAddr,
    StLdr1,
    StLdr2,
    StStr1,
    StStr2
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch1;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_byte_enable = 2'b11;

  always_comb begin
    state_d        = state_q;
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    pcmux_sel      = 1'b0;
    storemux_sel   = 1'b0;
    alumux_sel     = 1'b0;
    regfilemux_sel = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    aluop          = AluAdd;
    mem_read       = 1'b0;
    mem_write      = 1'b0;

    unique case (state_q)
      StFetch1: begin
        load_mar = 1'b1;
        load_pc  = 1'b1;
        state_d  = StFetch2;
      end
      StFetch2: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
        if (mem_resp) state_d = StFetch3;
      end
      StFetch3: begin
        load_ir = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpAdd:        state_d = StAdd;
          OpAnd:        state_d = StAnd;
          OpNot:        state_d = StNot;
          OpBr:         state_d = StBr;
          OpLdr, OpStr: state_d = StCalcAddr;
          default:      state_d = StFetch1;
        endcase
      end
      StAdd, StAnd, StNot: begin
        load_regfile = 1'b1;
        load_cc      = 1'b1;
        if (state_q == StAnd) aluop = AluAnd;
        else if (state_q == StNot) aluop = AluNot;
        state_d = StFetch1;
      end
      StBr: begin
        state_d = branch_enable ? StBrTaken : StFetch1;
      end
      StBrTaken: begin
        pcmux_sel = 1'b1;
        load_pc   = 1'b1;
        state_d   = StFetch1;
      end
      StCalcAddr: begin
        alumux_sel = 1'b1;
        marmux_sel = 1'b1;
        load_mar   = 1'b1;
        state_d    = (opcode == OpLdr) ? StLdr1 : StStr1;
      end
      StLdr1: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
        if (mem_resp) state_d = StLdr2;
      end
      StLdr2: begin
        regfilemux_sel = 1'b1;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
        state_d        = StFetch1;
      end
      StStr1: begin
        storemux_sel = 1'b1;
        aluop        = AluPass;
        mdrmux_sel   = 1'b1;
        load_mdr     = 1'b1;
        state_d      = StStr2;
      end
      StStr2: begin
        storemux_sel = 1'b1;
        mem_write    = 1'b1;
        if (mem_resp) state_d = StFetch1;
      end
      default: state_d = StFetch1;
    endcase

    // Reset gates every side effect in the same cycle, before the register recovers.
    if (reset) begin
      load_pc      = 1'b0;
      load_ir      = 1'b0;
      load_regfile = 1'b0;
      load_mar     = 1'b0;
      load_mdr     = 1'b0;
      load_cc      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
    end
  end

endmodule

// File: doc/control.md
# control

Moore-style control state machine for the LC-3b multicycle core. Sits directly upstream of `datapath`: it takes the opcode and branch-enable flag back from the datapath, sequences fetch/decode/execute, and drives every load enable and mux select into the datapath. It also drives the memory read/write handshake. Supported instructions are ADD, AND, NOT, BR, LDR and STR (register-operand forms only).

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `opcode`  in  4  (lc3b_opcode) IR[15:12] from datapath
- `branch_enable`  in  1  nzp compare result from datapath
- `mem_resp`  in  1  memory completion strobe, one cycle
- `load_pc`, `load_ir`, `load_regfile`, `load_mar`, `load_mdr`, `load_cc`  out  1 each  datapath register enables
- `pcmux_sel`  out  1  0 = PC+2, 1 = branch target
- `storemux_sel`  out  1  0 = SR1 field, 1 = DEST field as regfile src_a
- `alumux_sel`  out  1  0 = SR2 value, 1 = adj6(offset6)
- `regfilemux_sel`  out  1  0 = ALU out, 1 = MDR
- `marmux_sel`  out  1  0 = PC, 1 = ALU out
- `mdrmux_sel`  out  1  0 = mem_rdata, 1 = ALU out
- `aluop`  out  3  (lc3b_aluop) add=000, and=001, not=010, pass=011
- `mem_read`, `mem_write`  out  1 each  memory request, held until `mem_resp`
- `mem_byte_enable`  out  2  constant 2'b11 (word access only)

## Operation
- Outputs are a pure combinational decode of the current state. Any output not listed for a state is 0; `aluop` defaults to add.
- While `reset` is high, all load enables and `mem_read`/`mem_write` are forced to 0 in the same cycle. The state register takes FETCH1 on the next edge.
- States and actions:
  - FETCH1: marmux_sel=0, load_mar, pcmux_sel=0, load_pc. Next state is FETCH2.
  - FETCH2: mem_read, mdrmux_sel=0, load_mdr. Stays in FETCH2 until `mem_resp`=1, then goes to FETCH3.
  - FETCH3: load_ir. Next state is DECODE.
  - DECODE: no outputs. Branches on `opcode`: 0001 to S_ADD, 0101 to S_AND, 1001 to S_NOT, 0000 to S_BR, 0110 or 0111 to CALC_ADDR. Any other opcode goes to FETCH1 (treated as a NOP).
  - S_ADD / S_AND / S_NOT: aluop add/and/not, alumux_sel=0, regfilemux_sel=0, load_regfile, load_cc. Next state is FETCH1.
  - S_BR: no outputs. Goes to BR_TAKEN if `branch_enable`, else FETCH1.
  - BR_TAKEN: pcmux_sel=1, load_pc. Next state is FETCH1.
  - CALC_ADDR: alumux_sel=1, aluop add, marmux_sel=1, load_mar. Goes to LDR1 if opcode is 0110, else STR1.
  - LDR1: mem_read, mdrmux_sel=0, load_mdr. Waits for `mem_resp`, then goes to LDR2.
  - LDR2: regfilemux_sel=1, load_regfile, load_cc. Next state is FETCH1.
  - STR1: storemux_sel=1, aluop pass, mdrmux_sel=1, load_mdr. Next state is STR2.
  - STR2: mem_write, storemux_sel=1. Waits for `mem_resp`, then goes to FETCH1.
- `mem_resp` is ignored in every state except FETCH2, LDR1 and STR2.
- `opcode` is sampled only in DECODE and CALC_ADDR. The IR is stable from FETCH3 onward.
- `branch_enable` is sampled only in S_BR.

## Timing
- Cycle counts assume `mem_resp` arrives in the first wait cycle. Each extra wait cycle adds 1.
  - ALU ops: 5 cycles.
  - BR not taken: 5 cycles. BR taken: 6 cycles.
  - LDR: 7 cycles. STR: 7 cycles.
- The memory handshake behaves as follows:
  - `mem_read`/`mem_write` rise on the cycle the wait state is entered.
  - They stay high through the cycle `mem_resp` is seen.
  - They drop on the following edge.
  - Back-to-back requests are never issued without an intervening non-memory state.
- `mem_read` and `mem_write` are never high in the same cycle.
- `load_mdr` is high in every cycle of FETCH2 and LDR1. The MDR value latched on the `mem_resp` cycle is the final one.
- Reset mid-transaction: request lines drop in the reset cycle, and the machine is in FETCH1 on the next edge. No pending `mem_resp` is honoured afterwards.
- `reset` held for several cycles: the machine stays in FETCH1 with outputs gated. Fetch starts on the first edge after `reset` falls.

## Test plan
1. Reset, then ADD (opcode 0001) with `mem_resp` on the first FETCH2 cycle. Required: states FETCH1, FETCH2, FETCH3, DECODE, S_ADD, FETCH1; load_regfile=1 and load_cc=1 for exactly one cycle; aluop=000.
2. LDR (0110) with fetch `mem_resp` delayed 3 cycles and data `mem_resp` delayed 2 cycles. Required: mem_read high for exactly 4 then 3 cycles; regfilemux_sel=1 in LDR2; total 12 cycles.
3. STR (0111) with immediate `mem_resp`. Required: STR1 drives aluop=011, mdrmux_sel=1, load_mdr=1. STR2 drives mem_write=1, mem_read=0, mem_byte_enable=11. Return to FETCH1 after 7 cycles.
4. BR (0000), first with branch_enable=1, then with branch_enable=0. Required: taken path has pcmux_sel=1 and load_pc=1 in BR_TAKEN, 6 cycles; not-taken path returns to FETCH1 after 5 cycles with no load_pc.
5. Illegal opcode 1111. Required: DECODE goes straight to FETCH1, and no regfile, cc or memory activity occurs.
6. Assert `reset` during the second cycle of FETCH2 with `mem_resp` arriving in the same cycle. Required: mem_read and load_mdr are 0 that cycle; state is FETCH1 on the next edge; FETCH3 is not entered.
